// File: rtl/shared_l2cache_pkg.sv
// Shared attributes for the L2 line store: default geometry, core/address/word
// types and the controller state encoding.
package cache_attrs;

  localparam int N_CORES     = 4;
  localparam int CORE_ADDR_W = 14;
  localparam int CORE_DATA_W = 64;
  localparam int STORE_DEPTH = 64;

  localparam int CORE_ID_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int LINE_IDX_W = $clog2(STORE_DEPTH);
  localparam int LINE_TAG_W = CORE_ADDR_W - LINE_IDX_W;

  typedef logic [CORE_ID_W-1:0]   core_id_t;
  typedef logic [CORE_ADDR_W-1:0] fb_addr_t;
  typedef logic [CORE_DATA_W-1:0] fb_word_t;
  typedef logic [LINE_IDX_W-1:0]  line_idx_t;
  typedef logic [LINE_TAG_W-1:0]  line_tag_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FETCH,
    ST_WRITE,
    ST_INV,
    ST_RESP
  } state_t;

endpackage

// File: rtl/shared_l2cache_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping; the pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            grant_valid
);

  // Scanning from the farthest offset down lets the nearest request win last.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant       = ID_W'((int'(ptr) + i) % N);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_l2cache.sv
// Shared L2 front end: round-robin arbitration of core ports onto one fb port,
// with a direct-mapped write-through line store and write-invalidate handshake.
module shared_l2cache
  import cache_attrs::*;
#(
  parameter int N_PORTS = N_CORES,
  parameter int ADDR_W  = CORE_ADDR_W,
  parameter int DATA_W  = CORE_DATA_W,
  parameter int DEPTH   = STORE_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS-1:0]              en,
  input  logic [N_PORTS-1:0]              w,
  input  logic [N_PORTS-1:0][ADDR_W-1:0]  addr,
  input  logic [N_PORTS-1:0][DATA_W-1:0]  d_in,
  output logic [N_PORTS-1:0][DATA_W-1:0]  d_out,
  output logic [N_PORTS-1:0]              ready,
  output logic [N_PORTS-1:0]              invalidate,
  output logic [ADDR_W-1:0]               inv_addr,
  input  logic [N_PORTS-1:0]              invalidated,
  output logic                            fb_en,
  output logic                            fb_w,
  output logic [ADDR_W-1:0]               fb_addr,
  output logic [DATA_W-1:0]               fb_in,
  input  logic [DATA_W-1:0]               fb_out,
  input  logic                            fb_ready
);

  localparam int ID_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W;

  state_t                          state_q, state_d;
  logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                 grant_q, grant_d;
  logic                            w_q, w_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [DATA_W-1:0]               data_q, data_d;
  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [N_PORTS-1:0]              ready_q, ready_d;
  logic [N_PORTS-1:0][DATA_W-1:0]  d_out_q, d_out_d;
  logic [N_PORTS-1:0]              inv_q, inv_d;
  logic [ADDR_W-1:0]               inv_addr_q, inv_addr_d;
  logic                            fb_en_q, fb_en_d;
  logic                            fb_w_q, fb_w_d;
  logic [ADDR_W-1:0]               fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0]               fb_in_q, fb_in_d;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [ID_W-1:0]    arb_grant;
  logic               arb_valid;
  logic [IDX_W-1:0]   line_idx;
  logic [TAG_W-1:0]   line_tag;
  logic               line_hit;
  logic               line_we;
  logic [DATA_W-1:0]  line_data;
  logic [N_PORTS-1:0] writer_mask;

  rr_arbiter #(.N(N_PORTS), .ID_W(ID_W)) u_arb (
    .req         (en),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign line_idx    = addr_q[IDX_W-1:0];
  assign line_tag    = addr_q[ADDR_W-1:IDX_W];
  assign line_hit    = valid_q[line_idx] && (tag_mem[line_idx] == line_tag);
  assign writer_mask = N_PORTS'(1) << grant_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    w_d        = w_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ready_d    = '0;
    d_out_d    = '0;
    inv_d      = inv_q;
    inv_addr_d = inv_addr_q;
    fb_en_d    = fb_en_q;
    fb_w_d     = fb_w_q;
    fb_addr_d  = fb_addr_q;
    fb_in_d    = fb_in_q;
    line_we    = 1'b0;
    line_data  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          w_d     = w[arb_grant];
          addr_d  = addr[arb_grant];
          data_d  = d_in[arb_grant];
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (w_q) begin
          fb_en_d   = 1'b1;
          fb_w_d    = 1'b1;
          fb_addr_d = addr_q;
          fb_in_d   = data_q;
          state_d   = ST_WRITE;
        end else if (line_hit) begin
          ready_d[grant_q] = 1'b1;
          d_out_d[grant_q] = data_mem[line_idx];
          state_d          = ST_RESP;
        end else begin
          fb_en_d   = 1'b1;
          fb_w_d    = 1'b0;
          fb_addr_d = addr_q;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fb_ready) begin
          fb_en_d           = 1'b0;
          fb_addr_d         = '0;
          line_we           = 1'b1;
          line_data         = fb_out;
          valid_d[line_idx] = 1'b1;
          ready_d[grant_q]  = 1'b1;
          d_out_d[grant_q]  = fb_out;
          state_d           = ST_RESP;
        end
      end
      ST_WRITE: begin
        // Hit or miss, the line ends up holding this address and the new word.
        if (fb_ready) begin
          fb_en_d           = 1'b0;
          fb_w_d            = 1'b0;
          fb_addr_d         = '0;
          fb_in_d           = '0;
          line_we           = 1'b1;
          valid_d[line_idx] = 1'b1;
          if (N_PORTS == 1) begin
            ready_d[grant_q] = 1'b1;
            d_out_d[grant_q] = data_q;
            state_d          = ST_RESP;
          end else begin
            inv_d      = ~writer_mask;
            inv_addr_d = addr_q;
            state_d    = ST_INV;
          end
        end
      end
      ST_INV: begin
        inv_d = inv_q & ~invalidated;
        if (inv_d == '0) begin
          inv_addr_d       = '0;
          ready_d[grant_q] = 1'b1;
          d_out_d[grant_q] = data_q;
          state_d          = ST_RESP;
        end
      end
      ST_RESP: begin
        rr_ptr_d = (grant_q == ID_W'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      w_q        <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      ready_q    <= '0;
      d_out_q    <= '0;
      inv_q      <= '0;
      inv_addr_q <= '0;
      fb_en_q    <= 1'b0;
      fb_w_q     <= 1'b0;
      fb_addr_q  <= '0;
      fb_in_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      w_q        <= w_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      d_out_q    <= d_out_d;
      inv_q      <= inv_d;
      inv_addr_q <= inv_addr_d;
      fb_en_q    <= fb_en_d;
      fb_w_q     <= fb_w_d;
      fb_addr_q  <= fb_addr_d;
      fb_in_q    <= fb_in_d;
    end
  end

  // Tag/data arrays need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[line_idx]  <= line_tag;
      data_mem[line_idx] <= line_data;
    end
  end

  assign d_out      = d_out_q;
  assign ready      = ready_q;
  assign invalidate = inv_q;
  assign inv_addr   = inv_addr_q;
  assign fb_en      = fb_en_q;
  assign fb_w       = fb_w_q;
  assign fb_addr    = fb_addr_q;
  assign fb_in      = fb_in_q;

endmodule

// File: doc/shared_l2cache.md
Name: shared_l2cache

Overview:
Parametrised successor to the shared-framebuffer front end, sitting between N_PORTS core-side L1 request ports and the single framebuffer (fb) memory port.
- Adds a direct-mapped, write-through line store, so read hits complete without an fb access.
- Replaces fixed arbitration with round-robin.
- Sends write-invalidates only to non-writer ports and waits for their acknowledgements before completing the write.

Parameters:
- N_PORTS, 4: number of requesting cores; must be ≥1.
- ADDR_W, 14: word-address width.
- DATA_W, 64: word width.
- DEPTH, 64: store entries; power of two; index = addr[log2(DEPTH)-1:0], tag = remaining upper bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- en  in  [N_PORTS]  request valid per port
- w  in  [N_PORTS]  1 = write, 0 = read
- addr  in  [N_PORTS]×ADDR_W  request address
- d_in  in  [N_PORTS]×DATA_W  write data
- d_out  out  [N_PORTS]×DATA_W  read data, valid with ready
- ready  out  [N_PORTS]  one-cycle completion pulse
- invalidate  out  [N_PORTS]  invalidate request per port
- inv_addr  out  ADDR_W  address being invalidated
- invalidated  in  [N_PORTS]  invalidate acknowledge per port
- fb_en  out  1  fb request
- fb_w  out  1  fb write
- fb_addr  out  ADDR_W  fb address
- fb_in  out  DATA_W  fb write data
- fb_out  in  DATA_W  fb read data
- fb_ready  in  1  fb completion, sampled at clock edge

Behaviour:
- Reset values: all outputs 0; all valid bits cleared; round-robin pointer = 0; FSM = IDLE. An assertion of rst mid-transaction aborts immediately: fb_en drops asynchronously and no ready is issued.
- Arbitration (IDLE):
  - Among ports with en=1, grant the first at or after rr_ptr, wrapping.
  - Latch grant and that port's w/addr/d_in.
  - With no requests, stay in IDLE.
  - A port that drops en before it is granted is simply not served.
- LOOKUP (1 cycle): compare the tag and valid bit at the index.
  - Read hit → RESP, with d_out = stored line.
  - Read miss → FETCH.
  - Write → WRITE.
- FETCH: hold fb_en=1, fb_w=0, fb_addr=latched addr until fb_ready is sampled high. Then fill the line (valid=1, tag, data), take d_out = fb_out, go to RESP.
- WRITE:
  - Hold fb_en=1, fb_w=1, fb_addr, fb_in=d_in until fb_ready.
  - Update the line on a tag hit; allocate the line on a miss.
  - Then go to INV. If N_PORTS=1, go straight to RESP.
- INV:
  - Drive inv_addr = addr; invalidate[i]=1 for every i ≠ grant.
  - Collect sticky acks: a port is done on the first sampled edge with invalidated[i]=1 while its invalidate is high.
  - Deassert each port's invalidate once its ack is collected.
  - When every non-writer port has acked, go to RESP.
- RESP (1 cycle):
  - ready[grant]=1 for exactly one cycle; d_out[grant] is valid (writes return the written data).
  - Set rr_ptr = grant+1 mod N_PORTS; return to IDLE.
  - ready and d_out for other ports stay 0.
- Requester rule: drop en in the cycle ready is seen. If en is still high at the next edge, it is treated as a new request.
- A granted transaction completes even if en drops mid-flight.
- Latency:
  - Read hit: ready 2 cycles after grant.
  - Miss: fb_en rises 2 cycles after grant; ready 1 cycle after fb_ready is sampled.
- fb_ready while fb_en=0 is ignored.
- invalidated from a port not being invalidated is ignored.
- fb_en is never deasserted before fb_ready.
- Only one transaction is in flight; no reordering.

Decomposition:
- Package cache_attrs holds:
  - N_CORES (passed as N_PORTS)
  - core_id_t, fb_addr_t, fb_word_t
  - line index/tag typedefs
  - the FSM state enum
- One sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; outputs grant id and grant_valid. The arbiter is combinational; ptr is owned by shared_l2cache.

Test Plan:
1. Port0 reads addr 17 (cold); fb returns 64'h6768697071727374 after 2 cycles → fb_w=0, fb_addr=17, ready[0] pulse with d_out[0]=fb_out. Port0 then rereads 17 → ready 2 cycles after grant, fb_en never asserted.
2. Ports 0, 1, 2 assert reads to 123, 321, 555 simultaneously with rr_ptr=0; fb echoes the address → service order 0, 1, 2, each d_out[i]=addr[i]. Repeat with rr_ptr=2 → order 2, 0, 1.
3. Port1 writes 64'hdeadbeeffeddeeda to 243 → fb_w=1, fb_in matches; invalidate[0,2,3]=1, invalidate[1]=0, inv_addr=243. Acks arrive staggered 1, 3, 5 cycles later → ready[1] one cycle after the last ack. A later port0 read of 243 hits with the new data.
4. Alias eviction with DEPTH=64: read 5, then read 69 (same index) → second read misses and fetches; reread of 5 misses again.
5. Reset asserted during FETCH with fb_en high → fb_en=0 before the next edge, no ready pulse. After reset, reread of the same addr → miss.
6. Port3 raises en then drops it while port0 is being served → port3 is never granted; no spurious ready[3].
